// File: rtl/fetch_redirect_pkg.sv
// Shared fetch-stage definitions: redirect/IF-ID bus layouts, fetch FSM encoding
// and the reset/exception address defaults used by the CPU front end.
package fetch_redirect_pkg;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned REDIR_W = ADDR_W + 1;
    localparam int unsigned IFID_W  = 2 * ADDR_W;

    localparam logic [ADDR_W-1:0] RESET_PC_DEF       = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] EXC_ENTER_ADDR_DEF = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] INST_BYTES         = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    // {valid, pc} layout shared by the exception and branch redirect buses.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
    } redirect_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_redirect_next_pc_sel.sv
// Next fetch address selection: exception beats flush, flush beats branch,
// and with no redirect the fetch walks forward sequentially.
module next_pc_sel
    import fetch_redirect_pkg::*;
(
    input  redirect_t         exc_i,
    input  logic              cancel_i,
    input  logic [ADDR_W-1:0] cancel_pc_i,
    input  redirect_t         jbr_i,
    input  logic [ADDR_W-1:0] seq_pc_i,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] next_pc_o
);

    always_comb begin
        redirect_o = exc_i.valid | cancel_i | jbr_i.valid;
        if (exc_i.valid) begin
            next_pc_o = word_align(exc_i.pc);
        end else if (cancel_i) begin
            next_pc_o = cancel_pc_i;
        end else if (jbr_i.valid) begin
            next_pc_o = word_align(jbr_i.pc);
        end else begin
            next_pc_o = seq_pc_i;
        end
    end

endmodule

// File: rtl/fetch_redirect.sv
// Instruction fetch unit: one outstanding memory request at a time, with
// redirects from writeback (exception/flush) and decode (taken branches).
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC       = RESET_PC_DEF,
    parameter logic [ADDR_W-1:0] EXC_ENTER_ADDR = EXC_ENTER_ADDR_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [REDIR_W-1:0] exc_bus,
    input  logic               cancel,
    input  logic [REDIR_W-1:0] jbr_bus,
    input  logic               next_fetch,
    output logic               inst_req,
    output logic [ADDR_W-1:0]  inst_addr,
    input  logic               inst_addr_ok,
    input  logic               inst_data_ok,
    input  logic [ADDR_W-1:0]  inst_rdata,
    output logic               IF_valid,
    output logic [IFID_W-1:0]  IF_ID_bus,
    output logic [ADDR_W-1:0]  IF_pc
);

    // EXC_ENTER_ADDR only documents the vector; the live exception PC rides on exc_bus.
    if (EXC_ENTER_ADDR[1:0] != 2'b00) begin : g_exc_entry_misaligned
    end

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pending_q, pending_d;
    logic [IFID_W-1:0] ifid_q, ifid_d;

    redirect_t         exc, jbr, jbr_live;
    logic [ADDR_W-1:0] pc_plus4, cancel_pc, next_pc;
    logic              redirect;

    assign exc      = exc_bus;
    assign jbr      = jbr_bus;
    assign pc_plus4 = pc_q + INST_BYTES;

    // Branches from decode are stale once a drop is in flight.
    always_comb begin
        jbr_live       = jbr;
        jbr_live.valid = jbr.valid & (state_q != ST_DROP);
    end

    // A flush resumes after the instruction it killed, never re-fetching it.
    always_comb begin
        cancel_pc = pc_plus4;
        if (state_q == ST_REQ && !inst_addr_ok) begin
            cancel_pc = pc_q;
        end else if (state_q == ST_DROP) begin
            cancel_pc = pending_q;
        end
    end

    next_pc_sel u_next_pc_sel (
        .exc_i       (exc),
        .cancel_i    (cancel),
        .cancel_pc_i (cancel_pc),
        .jbr_i       (jbr_live),
        .seq_pc_i    (pc_plus4),
        .redirect_o  (redirect),
        .next_pc_o   (next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pending_d = pending_q;
        ifid_d    = ifid_q;
        unique case (state_q)
            ST_REQ: begin
                if (redirect && inst_addr_ok) begin
                    pending_d = next_pc;
                    state_d   = ST_DROP;
                end else if (redirect) begin
                    pc_d = next_pc;
                end else if (inst_addr_ok) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect && inst_data_ok) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end else if (redirect) begin
                    pending_d = next_pc;
                    state_d   = ST_DROP;
                end else if (inst_data_ok) begin
                    ifid_d  = {pc_q, inst_rdata};
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect || next_fetch) begin
                    pc_d    = next_pc;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    pending_d = next_pc;
                end
                if (inst_data_ok) begin
                    pc_d      = redirect ? next_pc : pending_q;
                    pending_d = '0;
                    state_d   = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_REQ;
            pc_q      <= word_align(RESET_PC);
            pending_q <= '0;
            ifid_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pending_q <= pending_d;
            ifid_q    <= ifid_d;
        end
    end

    // Requests are masked while reset is held so memory sees nothing until release.
    assign inst_req  = (state_q == ST_REQ) & ~reset;
    assign inst_addr = pc_q;
    assign IF_valid  = (state_q == ST_HOLD);
    assign IF_ID_bus = ifid_q;
    assign IF_pc     = pc_q;

endmodule

// File: tb/tb_fetch_redirect.sv
// Bench for fetch_redirect: directed redirect/boundary scenarios followed by a
// randomized run, all compared cycle by cycle against a reference fetch model.
module tb_fetch_redirect;
    import fetch_redirect_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [32:0] exc_bus;
    logic        cancel;
    logic [32:0] jbr_bus;
    logic        next_fetch;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        IF_valid;
    logic [63:0] IF_ID_bus;
    logic [31:0] IF_pc;

    int errors = 0;
    int checks = 0;

    // Stimulus knobs for the next cycle
    logic        excV, cancelV, jbrV, nfV;
    logic [31:0] excPc, jbrPc;
    int          addrOkPct, memDelay;
    bit          randDelay, forceDataOk;

    // Instruction memory responder
    bit          memBusy;
    int          memCnt;
    logic [31:0] memAddr;

    // Reference model: what the fetch unit is doing, in stream terms
    bit          mBusy, mDiscard, mHeld;
    logic [31:0] mPc, mTarget, mHeldPc, mHeldInst;

    fetch_redirect #(
        .RESET_PC       (RST_PC),
        .EXC_ENTER_ADDR (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .exc_bus      (exc_bus),
        .cancel       (cancel),
        .jbr_bus      (jbr_bus),
        .next_fetch   (next_fetch),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .IF_valid     (IF_valid),
        .IF_ID_bus    (IF_ID_bus),
        .IF_pc        (IF_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B9) ^ 32'h2408_0001;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mBusy    = 1'b0;
        mDiscard = 1'b0;
        mHeld    = 1'b0;
        mPc      = RST_PC;
        mTarget  = 32'h0;
        memBusy  = 1'b0;
        memCnt   = 0;
    endtask

    // Advance the model by one clock given this cycle's inputs.
    task automatic modelStep(input bit addrOk, input bit dataOk, input logic [31:0] rdata);
        logic [31:0] seqPc, tgt;
        bit dropping, jbrLive, redir;
        dropping = mBusy && mDiscard;
        if (mHeld || (mBusy && !mDiscard)) seqPc = mPc + 32'd4;
        else if (dropping)                 seqPc = mTarget;
        else                               seqPc = addrOk ? mPc + 32'd4 : mPc;
        jbrLive = (jbrV === 1'b1) && !dropping;
        redir   = (excV === 1'b1) || (cancelV === 1'b1) || jbrLive;
        tgt     = (excV === 1'b1) ? excPc : ((cancelV === 1'b1) ? seqPc : jbrPc);
        if (mHeld) begin
            if (redir) begin
                mHeld = 1'b0;
                mPc   = tgt;
            end else if (nfV === 1'b1) begin
                mHeld = 1'b0;
                mPc   = mPc + 32'd4;
            end
        end else if (!mBusy) begin
            if (addrOk) begin
                mBusy    = 1'b1;
                mDiscard = redir;
                mTarget  = tgt;
            end else if (redir) begin
                mPc = tgt;
            end
        end else if (!mDiscard) begin
            if (dataOk) begin
                mBusy = 1'b0;
                if (redir) begin
                    mPc = tgt;
                end else begin
                    mHeld     = 1'b1;
                    mHeldPc   = mPc;
                    mHeldInst = rdata;
                end
            end else if (redir) begin
                mDiscard = 1'b1;
                mTarget  = tgt;
            end
        end else begin
            if (redir) mTarget = tgt;
            if (dataOk) begin
                mBusy    = 1'b0;
                mDiscard = 1'b0;
                mPc      = mTarget;
            end
        end
    endtask

    // One clock: drive inputs at negedge, step model after posedge, compare.
    task automatic applyStimulus();
        bit          addrOk, dataOk, mReq;
        logic [31:0] rdata, reqAddr;
        reqAddr = inst_addr;
        addrOk  = (inst_req === 1'b1) && !memBusy && ($urandom_range(0, 99) < addrOkPct);
        dataOk  = (memBusy && memCnt == 0) || forceDataOk;
        rdata   = memBusy ? memWord(memAddr) : 32'hDEAD_BEEF;
        exc_bus      = {excV, excPc};
        cancel       = cancelV;
        jbr_bus      = {jbrV, jbrPc};
        next_fetch   = nfV;
        inst_addr_ok = addrOk;
        inst_data_ok = dataOk;
        inst_rdata   = rdata;
        @(posedge clk);
        #1;
        if (memBusy) begin
            if (memCnt == 0) memBusy = 1'b0;
            else             memCnt--;
        end
        if (addrOk) begin
            memBusy = 1'b1;
            memAddr = reqAddr;
            memCnt  = (randDelay ? int'($urandom_range(1, 5)) : memDelay) - 1;
        end
        modelStep(addrOk, dataOk, rdata);
        mReq = !mBusy && !mHeld;
        checkOutput("inst_req", inst_req, mReq);
        if (mReq) checkOutput("inst_addr", inst_addr, mPc);
        checkOutput("IF_valid", IF_valid, mHeld);
        if (mHeld) checkOutput("IF_ID_bus", IF_ID_bus, {mHeldPc, mHeldInst});
        @(negedge clk);
    endtask

    task automatic resetDut(input int cycles);
        exc_bus      = '0;
        cancel       = 1'b0;
        jbr_bus      = '0;
        next_fetch   = 1'b0;
        inst_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkOutput("rst_inst_req", inst_req, 1'b0);
        checkOutput("rst_IF_valid", IF_valid, 1'b0);
        checkOutput("rst_IF_ID_bus", IF_ID_bus, 64'h0);
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rel_inst_req", inst_req, 1'b1);
        checkOutput("rel_inst_addr", inst_addr, RST_PC);
        checkOutput("rel_IF_valid", IF_valid, 1'b0);
    endtask

    initial begin
        int          waitCnt;
        logic [63:0] heldBus;

        excV = 1'b0; cancelV = 1'b0; jbrV = 1'b0; nfV = 1'b1;
        excPc = 32'h0; jbrPc = 32'h0;
        addrOkPct = 100; memDelay = 1; randDelay = 1'b0; forceDataOk = 1'b0;
        inst_rdata = 32'h0;
        reset = 1'b0;
        resetDut(2);

        $display("[TB] sequential fetch, zero-wait memory");
        repeat (2) applyStimulus();
        checkOutput("first_bus", IF_ID_bus, 64'h0000_0000_2408_0001);
        applyStimulus();
        checkOutput("seq_addr", inst_addr, 32'h4);
        for (int k = 2; k <= 3; k++) begin
            repeat (3) applyStimulus();
            checkOutput("seq_addr", inst_addr, 32'(4 * k));
        end

        $display("[TB] branch before acceptance");
        addrOkPct = 0; jbrV = 1'b1; jbrPc = 32'h40;
        applyStimulus();
        jbrV = 1'b0; addrOkPct = 100;
        checkOutput("jbr_addr", inst_addr, 32'h40);
        repeat (2) applyStimulus();
        checkOutput("jbr_fetch_pc", IF_ID_bus[63:32], 32'h40);

        $display("[TB] exception with flush during a slow fetch");
        applyStimulus();
        memDelay = 5;
        applyStimulus();
        excV = 1'b1; excPc = 32'h0; cancelV = 1'b1;
        applyStimulus();
        excV = 1'b0; cancelV = 1'b0; addrOkPct = 0;
        waitCnt = 0;
        while (inst_req !== 1'b1 && waitCnt < 10) begin
            applyStimulus();
            checkOutput("drop_IF_valid", IF_valid, 1'b0);
            waitCnt++;
        end
        checkOutput("drop_ends", inst_req, 1'b1);
        checkOutput("drop_addr", inst_addr, 32'h0);
        memDelay = 1; addrOkPct = 100; nfV = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("refetch_bus", IF_ID_bus, 64'h0000_0000_2408_0001);

        $display("[TB] exception and branch together while holding");
        excV = 1'b1; excPc = 32'h100; jbrV = 1'b1; jbrPc = 32'h200; addrOkPct = 0;
        applyStimulus();
        excV = 1'b0; jbrV = 1'b0;
        checkOutput("hold_redir_valid", IF_valid, 1'b0);
        checkOutput("hold_redir_addr", inst_addr, 32'h100);

        $display("[TB] decode stall while holding");
        addrOkPct = 100;
        repeat (2) applyStimulus();
        heldBus = {32'h100, memWord(32'h100)};
        for (int i = 0; i < 10; i++) begin
            forceDataOk = (i == 4);
            applyStimulus();
            checkOutput("stall_bus", IF_ID_bus, heldBus);
            checkOutput("stall_req", inst_req, 1'b0);
        end
        forceDataOk = 1'b0; nfV = 1'b1;
        applyStimulus();
        addrOkPct = 0; forceDataOk = 1'b1;
        applyStimulus();
        forceDataOk = 1'b0;
        checkOutput("stray_data_req", inst_req, 1'b1);
        checkOutput("stray_data_addr", inst_addr, 32'h104);

        $display("[TB] address wrap");
        jbrV = 1'b1; jbrPc = 32'hFFFF_FFFC;
        applyStimulus();
        jbrV = 1'b0; addrOkPct = 100; nfV = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("wrap_pc", IF_ID_bus[63:32], 32'hFFFF_FFFC);
        nfV = 1'b1;
        applyStimulus();
        checkOutput("wrap_addr", inst_addr, 32'h0);

        $display("[TB] flush alone while holding");
        nfV = 1'b0;
        repeat (2) applyStimulus();
        cancelV = 1'b1;
        applyStimulus();
        cancelV = 1'b0;
        checkOutput("cancel_valid", IF_valid, 1'b0);
        checkOutput("cancel_addr", inst_addr, 32'h4);

        $display("[TB] reset while waiting on memory");
        memDelay = 3;
        applyStimulus();
        resetDut(2);
        memDelay = 1;
        repeat (2) applyStimulus();
        checkOutput("post_reset_bus", IF_ID_bus, {RST_PC, memWord(RST_PC)});

        $display("[TB] randomized traffic");
        randDelay = 1'b1; addrOkPct = 60;
        for (int i = 0; i < 3000; i++) begin
            excV    = ($urandom_range(0, 99) < 4);
            cancelV = excV && ($urandom_range(0, 1) != 0);
            excPc   = $urandom & 32'hFFFF_FFFC;
            jbrV    = ($urandom_range(0, 99) < 12);
            jbrPc   = $urandom & 32'hFFFF_FFFC;
            nfV     = ($urandom_range(0, 99) < 70);
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
